// File: rtl/restoring_divider_pkg.sv
// Shared constants for the arithmetic unit: divider state encodings and the
// default operand width used by both the multiplier and the divider.
`ifndef RESTORING_DIVIDER_PKG_SV
`define RESTORING_DIVIDER_PKG_SV

package restoring_divider_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

`endif

// File: rtl/restoring_divider_div_step.sv
// One restoring shift-subtract step of the divider; purely combinational.
module div_step
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_nxt,
    output logic [WIDTH-1:0] q_nxt
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // The shifted partial remainder keeps its carry bit so divisors above
    // 2^(WIDTH-1) still compare correctly; a fitting difference is always < D.
    always_comb begin
        r_sh  = {r, q[WIDTH-1]};
        fits  = (r_sh >= {1'b0, d});
        diff  = r_sh[WIDTH-1:0] - d;
        r_nxt = fits ? diff : r_sh[WIDTH-1:0];
        q_nxt = {q[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_DETECT_EN adds the div_zero flag and a zero-divisor bypass.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-subtract step per cycle, counter counts down
// DONE  | results valid, done pulse; start here is accepted back-to-back
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state, state_nxt;
    logic [WIDTH-1:0] r, q, d;
    logic [WIDTH-1:0] r_nxt, q_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             zero_bypass;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r     (r),
        .q     (q),
        .d     (d),
        .r_nxt (r_nxt),
        .q_nxt (q_nxt)
    );

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CW'(1));
`ifdef DIV_ZERO_DETECT_EN
    assign zero_bypass = (divisor == '0);
`else
    assign zero_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = zero_bypass ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (start) state_nxt = zero_bypass ? DONE : RUN;
                     else       state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r         <= '0;
            q         <= '0;
            d         <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_DETECT_EN
            div_zero  <= 1'b0;
`endif
        end else if (accept) begin
            r   <= '0;
            q   <= dividend;
            d   <= divisor;
            cnt <= CW'(WIDTH);
`ifdef DIV_ZERO_DETECT_EN
            div_zero <= zero_bypass;
            if (zero_bypass) begin
                quotient  <= '0;
                remainder <= dividend;
            end
`endif
        end else if (state == RUN) begin
            r   <= r_nxt;
            q   <= q_nxt;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                quotient  <= q_nxt;
                remainder <= r_nxt;
            end
        end
    end

endmodule
